// File: rtl/math_log2_34.sv
// ---------------------------------------------------------------------------
// math_log2_34
//
// Purpose:
//   Computes log2 of a 34-bit unsigned integer as a 12-bit unsigned 6.6
//   fixed-point value (integer part = msb position, fraction = 6 bits from
//   repeated mantissa squaring). It is the inverse of the 12-bit pow2 block.
//   The latency is fixed: capture, one NORM cycle, then one SQR cycle per
//   fraction bit. The result is held in DONE until the consumer accepts it.
//
// Configuration:
//   MATH_LOG2_ROUND_EN - when defined, a 7th SQR cycle yields a round bit.
//                        That bit is added to the 12-bit result
//                        (round-half-up), so the latency grows by one cycle.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   din        in  34   unsigned operand, captured on in_valid && in_ready
//   in_valid   in   1   din valid
//   in_ready   out  1   high only while IDLE (combinational)
//   dout       out 12   log2(din) in 6.6 fixed point (registered)
//   dout_err   out  1   result belongs to din == 0 (registered)
//   out_valid  out  1   dout/dout_err valid (registered)
//   out_ready  in   1   consumer accepts the result
// ---------------------------------------------------------------------------
module math_log2_34 (
    input  logic        clk,
    input  logic        rst,
    input  logic [33:0] din,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] dout,
    output logic        dout_err,
    output logic        out_valid,
    input  logic        out_ready
);

`ifdef MATH_LOG2_ROUND_EN
    localparam int FRAC_W = 7;
`else
    localparam int FRAC_W = 6;
`endif
    localparam logic [2:0] SQR_LAST = 3'(FRAC_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_SQR  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [33:0]         op_r;
    logic                zero_r;
    logic [5:0]          p_r;
    logic [15:0]         m_r;
    logic [2:0]          cnt_r;
    logic [FRAC_W-2:0]   frac_r;
    logic [11:0]         dout_r;
    logic                dout_err_r;
    logic                out_valid_r;

    logic [16:0]         sq_hi_s;
    logic                sq_bit_s;
    logic [15:0]         m_nx_s;
    logic [FRAC_W-1:0]   frac_nx_s;
    logic [11:0]         res_s;

    // Position of the most significant set bit (0 for a zero operand).
    function automatic logic [5:0] find_msb(input logic [33:0] v);
        logic [5:0] pos;
        pos = 6'd0;
        for (int i = 0; i < 34; i++) begin
            if (v[i]) begin
                pos = 6'(i);
            end else begin
                pos = pos;
            end
        end
        return pos;
    endfunction

    // Q1.15 mantissa: msb lands in bit 15; bits below the window are dropped.
    function automatic logic [15:0] norm_mant(input logic [33:0] v, input logic [5:0] pos);
        logic [15:0] mant;
        if (pos >= 6'd15) begin
            mant = 16'(v >> (pos - 6'd15));
        end else begin
            mant = 16'(v << (6'd15 - pos));
        end
        return mant;
    endfunction

    assign in_ready  = (state_r == ST_IDLE);
    assign dout      = dout_r;
    assign dout_err  = dout_err_r;
    assign out_valid = out_valid_r;

    // Squaring step: s = m*m in Q2.30; keep bits [31:15], renormalise when s >= 2.
    always_comb begin
        sq_hi_s   = 17'((32'(m_r) * 32'(m_r)) >> 15);
        sq_bit_s  = sq_hi_s[16];
        m_nx_s    = 16'd0;
        if (sq_bit_s) begin
            m_nx_s = sq_hi_s[16:1];
        end else begin
            m_nx_s = sq_hi_s[15:0];
        end
        frac_nx_s = {frac_r, sq_bit_s};
    end

    // Final result assembled from the last SQR bit; zero operand forces 0.
    always_comb begin
        res_s = 12'd0;
        if (zero_r) begin
            res_s = 12'd0;
        end else begin
`ifdef MATH_LOG2_ROUND_EN
            res_s = {p_r, frac_nx_s[6:1]} + {11'd0, frac_nx_s[0]};
`else
            res_s = {p_r, frac_nx_s};
`endif
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nx_s = ST_NORM;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_NORM: state_nx_s = ST_SQR;
            ST_SQR: begin
                if (cnt_r == SQR_LAST) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_SQR;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath: capture, normalise, squaring iterations and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r        <= 34'd0;
            zero_r      <= 1'b0;
            p_r         <= 6'd0;
            m_r         <= 16'd0;
            cnt_r       <= 3'd0;
            frac_r      <= '0;
            dout_r      <= 12'd0;
            dout_err_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r   <= din;
                        zero_r <= (din == 34'd0);
                    end
                end
                ST_NORM: begin
                    p_r    <= find_msb(op_r);
                    m_r    <= norm_mant(op_r, find_msb(op_r));
                    cnt_r  <= 3'd0;
                    frac_r <= '0;
                end
                ST_SQR: begin
                    m_r    <= m_nx_s;
                    frac_r <= frac_nx_s[FRAC_W-2:0];
                    cnt_r  <= cnt_r + 3'd1;
                    if (cnt_r == SQR_LAST) begin
                        dout_r      <= res_s;
                        dout_err_r  <= zero_r;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
